reg_alu_seq: RTL
================

// Module: reg_alu_seq
// PURPOSE
// - Instruction sequencer directly upstream of the register-file/ALU datapath.
// - Accepts packed instructions over a valid/ready handshake and buffers them in a FIFO.
// - Drives wr, sel, op, rd_addr_a, rd_addr_b, wr_addr and d_in for the datapath, one instruction at a time.
// - Captures the ALU carry on each write-back.
// PARAMETERS
// - FIFO_DEPTH  4  instruction FIFO entries; power of 2, >= 2
// - ALU_LAT     1  cycles from operand issue to a valid alu_res/alu_cout; >= 1
// PORTS
// - clk        in   1   clock, rising edge
// - reset      in   1   asynchronous, active-high; clears all state
// - flush      in   1   synchronous; empties FIFO, aborts current instruction
// - in_valid   in   1   instruction offered
// - in_ready   out  1   FIFO can accept; = !full
// - in_instr   in   29  {type[28], op[27:25], wa[24:22], ra[21:19], rb[18:16], imm[15:0]}
// - alu_cout   in   1   carry from ALU, valid in WB
// - wr         out  1   register-file write strobe
// - sel        out  1   0 = write d_in (immediate), 1 = write ALU result
// - op         out  3   ALU opcode
// - rd_addr_a  out  3   read port A address
// - rd_addr_b  out  3   read port B address
// - wr_addr    out  3   write address
// - d_in       out  16  immediate data
// - carry      out  1   carry of last completed ALU instruction
// - done       out  1   one-cycle pulse when an instruction retires
// - busy       out  1   state != IDLE or FIFO non-empty
// BEHAVIOUR
// - Reset values: every output 0; in_ready=1; FIFO empty; state IDLE; carry=0.
// - Push occurs when in_valid && in_ready.
// - When full, in_ready=0 even if a pop happens in the same cycle.
// - Simultaneous push and pop when not full: count unchanged.
// - Pointers wrap modulo FIFO_DEPTH.
// - type=1 LOADI: R[wa] <= imm.
// - type=0 ALU: R[wa] <= ALU(op, R[ra], R[rb]).
// - FSM states: IDLE, ISSUE, WAIT, WB.
// - IDLE: if FIFO non-empty, pop head into instruction register (ir) -> ISSUE.
// - ISSUE, LOADI: wr=1, sel=0, wr_addr=wa, d_in=imm, done=1 -> IDLE.
// - ISSUE, ALU: drive op, rd_addr_a=ra, rd_addr_b=rb; load wait counter with ALU_LAT-1.
//   - If ALU_LAT==1 -> WB; otherwise -> WAIT.
// - WAIT: hold op and addresses; decrement counter; at 0 -> WB.
// - WB: op and addresses still held; wr=1, sel=1, wr_addr=wa; carry<=alu_cout; done=1 -> IDLE.
// - Outputs are decoded from state and ir (Moore).
//   - wr, sel, d_in, op and addresses are 0 in IDLE.
//   - wr is high only in ISSUE(LOADI) and WB.
// - Latency, push to write (no bypass): LOADI wr at cycle 2; ALU wr at cycle 2+ALU_LAT.
//   - Cycle 0 = push edge.
// - Throughput: one LOADI per 2 cycles; one ALU op per 2+ALU_LAT cycles (IDLE visited between).
// - flush has priority over push and pop.
//   - Next cycle: FIFO empty, state IDLE.
//   - wr=0 in the flush cycle, so an aborted instruction never writes.
//   - carry is unchanged.
// - reset asserted mid-instruction: outputs go to reset values immediately; no write issued.
// - Unused instruction fields are ignored: imm for ALU; op/ra/rb for LOADI.
// CONFIGURATION
// - REG_ALU_SEQ_BYPASS_EN defined:
//   - In IDLE with FIFO empty and a push this cycle, the instruction loads ir directly -> ISSUE.
//   - It skips the FIFO; latency is 1 cycle shorter.
// - Not defined:
//   - Every instruction passes through the FIFO.
//   - Latencies as stated above.
// TESTING
// - LOADI wa=3 imm=16'hBEEF into empty block -> wr=1, sel=0, wr_addr=3, d_in=BEEF in cycle 2; done same cycle.
// - ALU op=2 wa=5 ra=3 rb=4, ALU_LAT=2, alu_cout=1 -> op/addresses stable 3 cycles; wr=1, sel=1 on last; carry=1.
// - Push 5 instructions back-to-back, FIFO_DEPTH=4, stalled:
//   - in_ready=0 after 4; 5th held.
//   - All 5 retire in order; done count = 5.
// - flush asserted in WAIT with 2 queued -> no wr pulse, busy=0 next cycle, carry unchanged.
// - reset pulsed asynchronously during WB -> wr, busy, done drop without a clock edge; FIFO empty.
// - With REG_ALU_SEQ_BYPASS_EN, LOADI into empty idle block -> wr at cycle 1 instead of 2.

Source files
------------

// File: rtl/reg_alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_alu_seq : instruction FIFO + sequencer feeding a regfile/ALU datapath |
// | Option REG_ALU_SEQ_BYPASS_EN: a push into an empty idle block skips FIFO. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module reg_alu_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [28:0] in_instr,
  input  logic        alu_cout,
  output logic        wr,
  output logic        sel,
  output logic [2:0]  op,
  output logic [2:0]  rd_addr_a,
  output logic [2:0]  rd_addr_b,
  output logic [2:0]  wr_addr,
  output logic [15:0] d_in,
  output logic        carry,
  output logic        done,
  output logic        busy
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WAIT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [WAIT_W-1:0] C_WAIT_LOAD = WAIT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0]  C_DEPTH     = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  logic [28:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  state_t            state_q, state_d;
  logic [28:0]       ir_q, ir_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic              carry_q, carry_d;

  logic full, empty, push, pop, bypass, fifo_wr;

  assign full     = (count_q == C_DEPTH);
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == S_IDLE) && !empty;

`ifdef REG_ALU_SEQ_BYPASS_EN
  assign bypass = push && empty && (state_q == S_IDLE);
`else
  assign bypass = 1'b0;
`endif
  assign fifo_wr = push && !bypass;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    wcnt_d  = wcnt_q;
    carry_d = carry_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;

    if (fifo_wr) wptr_d = wptr_q + 1'b1;
    if (pop)     rptr_d = rptr_q + 1'b1;
    case ({fifo_wr, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          ir_d    = mem_q[rptr_q];
          state_d = S_ISSUE;
        end else if (bypass) begin
          ir_d    = in_instr;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ir_q[28]) begin
          state_d = S_IDLE;
        end else begin
          wcnt_d  = C_WAIT_LOAD;
          state_d = (ALU_LAT == 1) ? S_WB : S_WAIT;
        end
      end
      S_WAIT: begin
        wcnt_d = wcnt_q - 1'b1;
        if (wcnt_q <= WAIT_W'(1)) state_d = S_WB;
      end
      S_WB: begin
        carry_d = alu_cout;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush beats push/pop and leaves the captured carry alone.
    if (flush) begin
      state_d = S_IDLE;
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      carry_d = carry_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      wcnt_q  <= '0;
      carry_q <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wcnt_q  <= wcnt_d;
      carry_q <= carry_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wptr_q] <= in_instr;
  end

  always_comb begin
    wr        = 1'b0;
    sel       = 1'b0;
    op        = 3'd0;
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd0;
    wr_addr   = 3'd0;
    d_in      = 16'd0;
    done      = 1'b0;
    case (state_q)
      S_ISSUE: begin
        if (ir_q[28]) begin
          wr      = 1'b1;
          wr_addr = ir_q[24:22];
          d_in    = ir_q[15:0];
          done    = 1'b1;
        end else begin
          op        = ir_q[27:25];
          rd_addr_a = ir_q[21:19];
          rd_addr_b = ir_q[18:16];
        end
      end
      S_WAIT: begin
        op        = ir_q[27:25];
        rd_addr_a = ir_q[21:19];
        rd_addr_b = ir_q[18:16];
      end
      S_WB: begin
        op        = ir_q[27:25];
        rd_addr_a = ir_q[21:19];
        rd_addr_b = ir_q[18:16];
        wr        = 1'b1;
        sel       = 1'b1;
        wr_addr   = ir_q[24:22];
        done      = 1'b1;
      end
      default: ;
    endcase
    // An instruction aborted by flush must never reach the register file.
    if (flush) begin
      wr   = 1'b0;
      done = 1'b0;
    end
  end

  assign carry = carry_q;
  assign busy  = (state_q != S_IDLE) || !empty;

endmodule
`default_nettype wire
